// File: rtl/imm_target_stage.sv
// imm_target_stage: decode-stage immediate/target generator with JAL redirect.
// Define IMM_TARGET_MISALIGN_EN to flag misaligned B/J targets and suppress their redirect.
module imm_target_stage #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_jump,
  output logic            out_branch,
  output logic            out_misalign,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] SQ_INIT = 3'(SQUASH_CYCLES);
  localparam bit         SQ_EN   = (SQUASH_CYCLES != 0);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef enum logic {
    ST_RUN,
    ST_SQUASH
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_e            fmt;
    logic            jump;
    logic            branch;
    logic            misalign;
  } beat_t;

  logic [6:0]  opc;
  logic        is_i;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;
  logic [31:0] imm32;
  beat_t       dec;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  beat_t           beat_q, beat_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            take;
  logic            jal_redir;

  assign opc  = in_instr[6:0];
  assign is_i = (opc == OPC_OP_IMM) | (opc == OPC_LOAD) |
                (opc == OPC_JALR) | (opc == OPC_SYSTEM);
  assign is_s = (opc == OPC_STORE);
  assign is_b = (opc == OPC_BRANCH);
  assign is_u = (opc == OPC_LUI) | (opc == OPC_AUIPC);
  assign is_j = (opc == OPC_JAL);

  always_comb begin
    dec   = '0;
    imm32 = '0;
    unique case (1'b1)
      is_i: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      is_s: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25],
                   in_instr[11:7]};
      end
      is_b: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31],
                   in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      is_u: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      is_j: begin
        dec.fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31],
                   in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
    // Widen to XLEN: upper bits replicate the instruction sign bit.
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
    if (is_b || is_j) begin
      dec.target = in_pc + dec.imm;
    end
    dec.jump   = (opc == OPC_JAL) | (opc == OPC_JALR);
    dec.branch = is_b;
`ifdef IMM_TARGET_MISALIGN_EN
    dec.misalign = (is_b | is_j) & dec.target[1];
`else
    dec.misalign = 1'b0;
`endif
  end

  assign in_ready  = (state_q == ST_SQUASH) | ~valid_q | out_ready;
  assign take      = in_valid & in_ready & ~flush;
  assign jal_redir = (dec.fmt == FMT_J) & ~dec.misalign;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    valid_d       = valid_q;
    beat_d        = beat_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (take) begin
            beat_d  = dec;
            valid_d = 1'b1;
            if (jal_redir) begin
              redirect_d    = 1'b1;
              redirect_pc_d = dec.target;
              if (SQ_EN) begin
                state_d = ST_SQUASH;
                cnt_d   = SQ_INIT;
              end
            end
          end else if (out_ready) begin
            valid_d = 1'b0;
          end
        end
        ST_SQUASH: begin
          if (out_ready) begin
            valid_d = 1'b0;
          end
          // Wrong-path beats are swallowed; only real beats count down.
          if (take) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
              cnt_d   = '0;
              state_d = ST_RUN;
            end
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      valid_q       <= 1'b0;
      beat_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      beat_q        <= beat_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_imm      = beat_q.imm;
  assign out_fmt      = beat_q.fmt;
  assign out_target   = beat_q.target;
  assign out_jump     = beat_q.jump;
  assign out_branch   = beat_q.branch;
  assign out_misalign = beat_q.misalign;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_imm_target_stage.sv
// tb_imm_target_stage: directed plus random stimulus against a reference model.
// Model works from format rules with plain integer arithmetic.
`timescale 1ns/1ps
module tb_imm_target_stage;

  localparam int XLEN = 32;
  localparam int SQ   = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_imm, out_target, redirect_pc;
  logic [2:0]  out_fmt;
  logic        out_jump, out_branch, out_misalign, redirect;

  int n_chk = 0;
  int n_err = 0;

  bit          m_valid, m_redir, m_jump, m_branch, m_mis;
  int          m_fmt, m_sq;
  logic [31:0] m_imm, m_tgt, m_rpc;

  always #5 clk = ~clk;

  imm_target_stage #(.XLEN(XLEN), .SQUASH_CYCLES(SQ)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt),
    .out_target(out_target), .out_jump(out_jump),
    .out_branch(out_branch), .out_misalign(out_misalign),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  function automatic void ref_decode(
    input  logic [31:0] i, input logic [31:0] pc,
    output int fmt, output logic [31:0] imm,
    output logic [31:0] tgt, output bit jmp, output bit mis);
    longint v;
    v   = 0;
    fmt = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin
        fmt = 1;
        v   = sx(longint'(i[31:20]), 12);
      end
      7'h23: begin
        fmt = 2;
        v   = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
      end
      7'h63: begin
        fmt = 3;
        v   = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                 longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin
        fmt = 4;
        v   = sx(longint'(i[31:12]) * 4096, 32);
      end
      7'h6F: begin
        fmt = 5;
        v   = sx(longint'(i[31]) * (1 << 20) +
                 longint'(i[19:12]) * (1 << 12) +
                 longint'(i[20]) * (1 << 11) +
                 longint'(i[30:21]) * 2, 21);
      end
      default: ;
    endcase
    imm = v[31:0];
    tgt = (fmt == 3 || fmt == 5) ? pc + imm : 32'h0;
    jmp = (i[6:0] == 7'h6F) || (i[6:0] == 7'h67);
`ifdef IMM_TARGET_MISALIGN_EN
    mis = (fmt == 3 || fmt == 5) && tgt[1];
`else
    mis = 1'b0;
`endif
  endfunction

  task automatic compare_outs();
    chk("out_valid", out_valid, m_valid);
    chk("redirect", redirect, m_redir);
    if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
    if (m_valid) begin
      chk("out_imm", out_imm, m_imm);
      chk("out_fmt", out_fmt, m_fmt);
      chk("out_target", out_target, m_tgt);
      chk("out_jump", out_jump, m_jump);
      chk("out_branch", out_branch, m_branch);
      chk("out_misalign", out_misalign, m_mis);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins,
                      input logic [31:0] pc, input bit ordy,
                      input bit fl);
    int          fmt;
    logic [31:0] imm, tgt;
    bit          jmp, mis, rdy, nred;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy = (m_sq > 0) || !m_valid || ordy;
    chk("in_ready", in_ready, rdy);
    ref_decode(ins, pc, fmt, imm, tgt, jmp, mis);
    nred = 1'b0;
    if (fl) begin
      m_valid = 1'b0;
      m_sq    = 0;
    end else if (m_sq > 0) begin
      if (v) m_sq--;
      if (ordy) m_valid = 1'b0;
    end else if (v && rdy) begin
      m_valid  = 1'b1;
      m_imm    = imm;
      m_fmt    = fmt;
      m_tgt    = tgt;
      m_jump   = jmp;
      m_branch = (fmt == 3);
      m_mis    = mis;
      if (fmt == 5 && !mis) begin
        nred  = 1'b1;
        m_rpc = tgt;
        m_sq  = SQ;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    m_redir = nred;
    @(posedge clk);
    #1;
    compare_outs();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    m_valid = 0; m_redir = 0; m_jump = 0; m_branch = 0; m_mis = 0;
    m_fmt = 0; m_sq = 0; m_imm = '0; m_tgt = '0; m_rpc = '0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_target", out_target, 0);
    chk("rst_out_fmt", out_fmt, 0);
    chk("rst_flags", {out_jump, out_branch, out_misalign}, 0);
    rst_n = 1'b1;
  endtask

  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h6F, 7'h33, 7'h00};

  initial begin
    logic [31:0] ins, pc;
    #2;
    do_reset();

    // Backward branch
    step(1, 32'hFE000EE3, 32'h100, 1, 0);
    chk("b_fmt", out_fmt, 3);
    chk("b_imm", out_imm, 32'hFFFFFFFC);
    chk("b_target", out_target, 32'h000000FC);
    chk("b_branch", out_branch, 1);
    chk("b_redirect", redirect, 0);

    // JAL +8 then three beats: two dropped, third captured
    do_reset();
    step(1, 32'h0080006F, 32'h200, 1, 0);
    chk("jal_redirect", redirect, 1);
    chk("jal_redirect_pc", redirect_pc, 32'h208);
    step(1, 32'h00100013, 32'h204, 1, 0);
    chk("jal_pulse_once", redirect, 0);
    step(1, 32'h00200013, 32'h208, 1, 0);
    chk("sq_drop", out_valid, 0);
    step(1, 32'h00300013, 32'h20C, 1, 0);
    chk("sq_third", out_imm, 32'h3);
    chk("sq_third_valid", out_valid, 1);

    // Stall holds the output
    do_reset();
    step(1, 32'h12300013, 32'h10, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h45600013, 32'h14, 0, 0);
      chk("stall_imm", out_imm, 32'h123);
      chk("stall_in_ready", in_ready, 0);
    end
    step(1, 32'h45600013, 32'h14, 1, 0);
    chk("release_imm", out_imm, 32'h456);

    // Flush in SQUASH with counter at 1
    do_reset();
    step(1, 32'h0080006F, 32'h200, 1, 0);
    step(1, 32'h00100013, 32'h204, 1, 0);
    step(1, 32'h00100013, 32'h208, 1, 1);
    chk("flush_valid", out_valid, 0);
    step(1, 32'h00700013, 32'h300, 1, 0);
    chk("post_flush_imm", out_imm, 32'h7);

    // JAL to a misaligned target
    do_reset();
    step(1, 32'h0020006F, 32'h0, 1, 0);
`ifdef IMM_TARGET_MISALIGN_EN
    chk("mis_flag", out_misalign, 1);
    chk("mis_no_redirect", redirect, 0);
`else
    chk("mis_flag", out_misalign, 0);
    chk("mis_redirect", redirect, 1);
    chk("mis_redirect_pc", redirect_pc, 32'h2);
`endif

    // Wrap-around target, then reset mid-squash
    do_reset();
    step(1, 32'h0080006F, 32'hFFFFFFFC, 1, 0);
    chk("wrap_target", out_target, 32'h4);
    step(1, 32'h00100013, 32'h0, 1, 0);
    do_reset();
    step(1, 32'h00900013, 32'h40, 1, 0);
    chk("post_rst_capture", out_imm, 32'h9);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      ins      = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      pc       = $urandom;
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      step($urandom_range(0, 3) != 0, ins, pc,
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_target_stage.md
# imm_target_stage

Registered decode-stage immediate generator and direct-target unit for the RISC-V PPU. Extracts and sign-extends the I/S/B/U/J immediates of one instruction per beat, computes PC-relative targets for JAL and branches, and holds the result in a valid/ready pipeline register. On an accepted JAL it pulses a fetch redirect and squashes a configurable number of wrong-path fetch beats. Sits between fetch and the ID/EX register.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- SQUASH_CYCLES, 2: wrong-path beats dropped after a JAL redirect; 0..7, 0 disables squashing.

- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  pipeline flush from EX; highest priority.
- in_valid  in  1  fetch beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_target  out  XLEN  in_pc+imm for B/J; 0 otherwise (JALR target resolved in EX).
- out_jump  out  1  JAL or JALR.
- out_branch  out  1  B-type.
- out_misalign  out  1  target misaligned (see Configuration).
- redirect  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  XLEN  redirect address.

## Operation
- Format by opcode[6:0]: 0010011/0000011/1100111/1110011 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; else NONE with imm 0.
- I: sext(instr[31:20]). S: sext({instr[31:25],instr[11:7]}). B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}). U: sext({instr[31:12],12'b0}). J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}). Sign bit always instr[31], extended to XLEN.
- Target: XLEN-bit add, wraps mod 2^XLEN, no overflow flag.
- out_jump = (opcode==1101111) | (opcode==1100111).
- States RUN and SQUASH, 3-bit counter.
- RUN: in_ready = !out_valid | out_ready. Beat accepted (in_valid & in_ready & !flush) loads all out_* fields and sets out_valid. out_valid clears when out_ready and nothing loads.
- Accepted J-type with out_misalign=0 and SQUASH_CYCLES>0: next cycle redirect=1, redirect_pc=target, state→SQUASH, counter=SQUASH_CYCLES. With SQUASH_CYCLES=0: redirect still pulses, state stays RUN.
- SQUASH: in_ready=1; each in_valid beat is consumed and dropped, counter decrements; at 0 → RUN. Cycles without in_valid do not decrement. Output register drains normally.
- flush: out_valid←0, state←RUN, counter←0, redirect←0; beat on the same cycle is not captured; flush with JAL accept gives no redirect.
- Reset: all outputs 0 (out_valid, redirect, out_imm, out_target, out_fmt, flags, redirect_pc), state RUN, counter 0.

## Timing
- Latency 1 cycle in_valid accept → out_valid.
- redirect asserted exactly the first cycle the JAL is out_valid; never held, even under out_ready=0.
- Stalled output (out_valid & !out_ready) holds all out_* stable.
- Full throughput: one beat/cycle with out_ready=1.

## Configuration
- IMM_TARGET_MISALIGN_EN defined: out_misalign = target[1] for B/J beats (bit0 always 0); misaligned JAL raises no redirect and no squash.
- Undefined: out_misalign tied 0; all JALs redirect.

## Test plan
- in_instr 0xFE000EE3, in_pc 0x100 → out_fmt 3, out_imm 0xFFFFFFFC, out_target 0x000000FC, out_branch 1, no redirect.
- in_instr 0x0080006F, in_pc 0x200, then 3 valid beats → redirect 1 cycle with redirect_pc 0x208; next 2 beats dropped, 3rd appears on out_valid.
- out_ready=0 for 4 cycles with beat held → out_* stable, in_ready 0; release → next beat accepted same cycle.
- flush asserted during SQUASH with counter 1 → next cycle state RUN, out_valid 0; following beat captured.
- in_instr 0x0020006F, pc 0x0 → with macro out_misalign 1, no redirect; without macro redirect_pc 0x2.
- XLEN 32, JAL +8 at pc 0xFFFFFFFC → out_target 0x00000004; rst_n low mid-squash → all outputs 0, state RUN.
